fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction-fetch front end sitting directly upstream of the instruction memory and directly downstream of nothing but the PC redirect sources (branch/jump resolution). It owns the PC register. It drives the word address into the combinational instruction memory and captures the returned word together with its PC into a small FIFO. The FIFO presents instructions to decode over a valid/ready handshake; a redirect flushes the FIFO and reloads the PC.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
DEPTH, 2, FIFO entries; power of two, >= 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
instr_addr  output  ADDR_WIDTH  byte address to instruction memory, equals current PC
instr  input  DATA_WIDTH  word returned combinationally by instruction memory for instr_addr
redirect_valid  input  1  branch/jump taken; load redirect_pc and flush
redirect_pc  input  ADDR_WIDTH  redirect target byte address
out_valid  output  1  head FIFO entry valid
out_ready  input  1  decode accepts head entry this cycle
out_instr  output  DATA_WIDTH  head entry instruction
out_pc  output  ADDR_WIDTH  head entry PC
empty  output  1  FIFO empty (== !out_valid)
full  output  1  FIFO holds DEPTH entries

Behaviour:
- Reset (rst_n low, async): pc = RESET_PC, read/write pointers = 0, count = 0; out_valid = 0, empty = 1, full = 0; out_instr/out_pc = 0 (entry storage cleared). Effective immediately, not at clock edge.
- instr_addr = pc (register output, no combinational path from any input).
- pop = out_valid & out_ready. push = !redirect_valid & (!full | pop).
- On push: entry[wptr] = {instr, pc}; wptr += 1 (mod DEPTH); pc = pc + 4 (ADDR_WIDTH wrap: 32'hFFFF_FFFC -> 0).
- On pop: rptr += 1 (mod DEPTH). count updates by push - pop; simultaneous push and pop when full is allowed (count unchanged).
- Redirect (redirect_valid high at edge): pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; count, rptr, wptr = 0; no push that cycle. A pop in the same cycle counts as accepted by decode but the queue is cleared regardless (redirect wins). Instruction fetched from redirect target is captured on the following edge.
- Latency: instruction at pc appears on out_* one cycle after the edge it is captured; first instruction valid one cycle after rst_n deasserts (first rising edge captures RESET_PC word).
- out_instr/out_pc/out_valid driven directly from storage/count registers (registered outputs); stable while out_valid & !out_ready, unless redirect or reset.
- Full: no push, pc holds, instr_addr holds. Empty: out_valid = 0; out_ready ignored.
- Back-to-back redirects: each one reloads pc; only the last takes effect; queue stays empty throughout.
- redirect_pc[1:0] nonzero: silently cleared, no error signalling.
- Sustained throughput: one instruction per cycle when out_ready held high and no redirect.

Test Plan:
- Reset release, memory word i = 32'h1000_0000+i, out_ready=1 -> cycle1 out_pc=0 out_instr=32'h1000_0000, then out_pc 4,8,12 with instr +1 each cycle, no bubbles.
- out_ready=0 from reset -> after 2 edges full=1, instr_addr stuck at 8, head remains pc 0; raise out_ready -> pcs 0,4,8,12 emitted in order, none dropped or duplicated.
- Full FIFO with out_ready=1 -> push and pop same edge, count stays 2, pc advances by 4 each cycle.
- redirect_valid=1, redirect_pc=32'h0000_0040 with 2 entries queued -> next cycle out_valid=0, instr_addr=32'h40; following cycle out_pc=32'h40, out_instr=32'h1000_0010.
- redirect_pc=32'h0000_0043 -> instr_addr=32'h40; redirect on consecutive cycles to 0x80 then 0xC0 -> first emitted out_pc=0xC0.
- pc at 32'hFFFF_FFFC via redirect -> next captured pc 0 (wrap); assert rst_n low mid-stream -> out_valid drops same cycle, instr_addr=RESET_PC before next edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch PC owner plus small capture FIFO toward decode; a word appears on out_* one cycle after capture.
// Backpressure: when the FIFO is full and decode stalls, the PC holds; a redirect flushes the queue and reloads the PC.
module fetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  empty,
    output logic                  full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         wptr;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;

    assign instr_addr = pc;
    assign out_valid  = (count != '0);
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign out_instr  = mem[rptr].instr;
    assign out_pc     = mem[rptr].pc;

    assign pop  = out_valid & out_ready;
    // A pop frees a slot in the same edge, so a full queue still streams.
    assign push = ~redirect_valid & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Redirect wins over any same-cycle pop; the queue restarts empty.
            pc    <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= '{instr: instr, pc: pc};
                wptr      <= wptr + PW'(1);
                pc        <= pc + ADDR_WIDTH'(4);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory word at byte address A is 32'h1000_0000 + A/4.
module tb_fetch_queue;
    logic        clk;
    logic        rst_n;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        empty;
    logic        full;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_addr    (instr_addr),
        .instr         (instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .empty         (empty),
        .full          (full)
    );

    assign instr = 32'h1000_0000 + (instr_addr >> 2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_addr", instr_addr, 0);

        // streaming from reset, no bubbles
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("strm_valid", out_valid, 1);
            chk("strm_pc", out_pc, 32'(4 * i));
            chk("strm_instr", out_instr, 32'h1000_0000 + 32'(i));
        end

        // async reset mid-stream
        rst_n     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_addr", instr_addr, 0);
        chk("arst_empty", empty, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // fill with decode stalled
        step();
        chk("fill1_full", full, 0);
        step();
        chk("fill2_full", full, 1);
        chk("fill2_addr", instr_addr, 32'h8);
        chk("fill2_head", out_pc, 0);
        step();
        chk("hold_full", full, 1);
        chk("hold_addr", instr_addr, 32'h8);
        chk("hold_head", out_pc, 0);
        chk("hold_instr", out_instr, 32'h1000_0000);

        // drain while full: push and pop same edge
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("drain_pc", out_pc, 32'(4 * k));
            chk("drain_instr", out_instr, 32'h1000_0000 + 32'(k));
            chk("drain_full", full, 1);
            chk("drain_addr", instr_addr, 32'(8 + 4 * k));
        end

        // redirect with two entries queued
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk("rd_valid", out_valid, 0);
        chk("rd_empty", empty, 1);
        chk("rd_addr", instr_addr, 32'h40);
        step();
        chk("rd_out_valid", out_valid, 1);
        chk("rd_out_pc", out_pc, 32'h40);
        chk("rd_out_instr", out_instr, 32'h1000_0010);

        // unaligned target, then back-to-back redirects
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        step();
        chk("unal_addr", instr_addr, 32'h40);
        chk("unal_valid", out_valid, 0);
        redirect_pc = 32'h80;
        step();
        chk("b2b1_addr", instr_addr, 32'h80);
        chk("b2b1_valid", out_valid, 0);
        redirect_pc = 32'hC0;
        step();
        chk("b2b2_addr", instr_addr, 32'hC0);
        chk("b2b2_valid", out_valid, 0);
        redirect_valid = 1'b0;
        step();
        chk("b2b_out_pc", out_pc, 32'hC0);
        chk("b2b_out_instr", out_instr, 32'h1000_0030);

        // pc wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        chk("wrap_addr0", instr_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr1", instr_addr, 32'h0);
        chk("wrap_head_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_head_instr", out_instr, 32'h4FFF_FFFF);
        step();
        chk("wrap_full", full, 1);
        chk("wrap_addr2", instr_addr, 32'h4);
        out_ready = 1'b1;
        step();
        chk("wrap_next_pc", out_pc, 32'h0);
        chk("wrap_next_instr", out_instr, 32'h1000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
